wavetable_scheduler: RTL and testbench
======================================

WAVETABLE_SCHEDULER -- requirements
Module: wavetable_scheduler

Interface
REQ-001 Parameter SHALL be: IDLE_LEVEL, 8'h80, sample value loaded for a disabled channel.
REQ-002 Port SHALL be: CLK  input  1  single clock, all logic on rising edge.
REQ-003 Port SHALL be: RST  input  1  reset, synchronous and active-high.
REQ-004 Port SHALL be: Tick  input  1  sample-rate pulse, one CLK wide, that starts a frame.
REQ-005 Port SHALL be: WavetableIndices  input  24  {idx3,idx2,idx1,idx0}, 6 bits each.
REQ-006 Port SHALL be: ChannelStatus  input  8  per channel n: bit 2n enable, bit 2n+1 bank select.
REQ-007 Port SHALL be: MemRE  output  1  wavetable read strobe.
REQ-008 Port SHALL be: MemAddr  output  7  {bank, index} of the shared 128x8 wavetable.
REQ-009 Port SHALL be: MemData  input  8  read data, valid the cycle after MemRE.
REQ-010 Port SHALL be: Samples  output  32  {s3,s2,s1,s0}, 8-bit unsigned held samples.
REQ-011 Port SHALL be: SampleValid  output  4  bit n pulses for one cycle when sn updates.
REQ-012 Port SHALL be: FrameStrobe  output  1  one-cycle pulse when all four channels have been serviced.
REQ-013 Port SHALL be: Busy  output  1  high in every state except IDLE.
REQ-014 Port SHALL be: OverrunClr  input  1  clears Overrun.
REQ-015 Port SHALL be: Overrun  output  1  sticky flag for a dropped Tick.

Function
REQ-016 FSM states SHALL be IDLE, READ, WAIT, DONE, with a 2-bit channel counter ch.
REQ-017 In IDLE, Tick=1 SHALL set ch=0 and move to READ; Tick=0 SHALL remain in IDLE.
REQ-018 In READ with channel ch enabled: MemRE=1 and MemAddr={ChannelStatus[2ch+1], idx_ch} sampled that cycle, then move to WAIT.
REQ-019 In READ with channel ch disabled: MemRE=0, s_ch<=IDLE_LEVEL, SampleValid[ch] pulses next cycle, then advance (REQ-021).
REQ-020 In WAIT: s_ch<=MemData and SampleValid[ch] pulses next cycle, then advance.
REQ-021 Advance SHALL mean: if ch==3 go to DONE, else ch<=ch+1 and go to READ; ch SHALL never wrap within a frame.
REQ-022 DONE SHALL assert FrameStrobe for exactly one cycle and then return to IDLE.
REQ-023 Latency with all channels enabled: Tick at cycle 0 -> FrameStrobe at cycle 9; all disabled -> cycle 5.
REQ-024 MemRE SHALL be asserted only in READ; at most one read SHALL be outstanding at a time.
REQ-025 MemAddr SHALL hold its last value when MemRE=0.
REQ-026 Samples SHALL hold their values between updates; a channel's enable/bank SHALL be sampled only in its own READ cycle.
REQ-027 A Tick while Busy=1 (READ/WAIT/DONE) SHALL be dropped and SHALL NOT restart or extend the frame.

Reset
REQ-028 RST=1 at a clock edge SHALL force IDLE, ch=0, Samples={4{IDLE_LEVEL}}, SampleValid=0, FrameStrobe=0, MemRE=0, MemAddr=0, Overrun=0.
REQ-029 Reset mid-frame SHALL abandon the frame without FrameStrobe; MemData returning after reset SHALL be ignored.
REQ-030 RST SHALL take priority over Tick in the same cycle.

Configuration
REQ-031 Macro WAVETABLE_SCHEDULER_OVERRUN_EN SHALL gate overrun detection.
REQ-032 With the macro defined: a dropped Tick SHALL set Overrun; OverrunClr SHALL clear it; a simultaneous set and clear SHALL leave Overrun set.
REQ-033 Without the macro: Overrun SHALL be tied 0, OverrunClr SHALL be ignored, and dropped Ticks SHALL be silent; the ports SHALL remain present.

Verification
REQ-034 Scenario 1: reset, then all channels enabled bank 0, indices 1/2/3/4, RAM[a]=a+8'h10, Tick -> MemAddr 1,2,3,4 on cycles 1,3,5,7; Samples=32'h14131211; FrameStrobe at cycle 9.
REQ-035 Scenario 2: ChannelStatus=8'b00_00_11_00 (ch1 enabled, bank 1, idx 5, RAM[69]=8'hAA) -> exactly one MemRE with MemAddr=69; Samples=32'h8080AA80; FrameStrobe at cycle 6.
REQ-036 Scenario 3: with the macro defined, Tick at cycles 0 and 4 -> second Tick dropped, Overrun=1 from cycle 5, one FrameStrobe; OverrunClr then clears it; without the macro, Overrun stays 0.
REQ-037 Scenario 4: RST asserted at cycle 4 of a frame -> IDLE next cycle, Samples=32'h80808080, no FrameStrobe, no SampleValid.
REQ-038 Scenario 5: Tick and RST in the same cycle -> remains in IDLE and MemRE never asserts; idx=63 with bank 1 -> MemAddr=127.

Source files
------------

// File: rtl/wavetable_scheduler.sv
// Four-channel wavetable sampler: each Tick starts one frame that reads a sample for every enabled channel.
// Frame takes 5..9 cycles. Ticks that arrive mid-frame are dropped. Option: WAVETABLE_SCHEDULER_OVERRUN_EN flags dropped Ticks.
module wavetable_scheduler #(
    parameter logic [7:0] IDLE_LEVEL = 8'h80
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Tick,
    input  logic [23:0] WavetableIndices,
    input  logic [7:0]  ChannelStatus,
    output logic        MemRE,
    output logic [6:0]  MemAddr,
    input  logic [7:0]  MemData,
    output logic [31:0] Samples,
    output logic [3:0]  SampleValid,
    output logic        FrameStrobe,
    output logic        Busy,
    input  logic        OverrunClr,
    output logic        Overrun
);

    typedef enum logic [1:0] {IDLE, READ, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  ch_q, ch_d;
    logic [6:0]  addr_q;
    logic [31:0] samples_q;
    logic        ch_en;
    logic        ch_bank;
    logic [5:0]  ch_idx;
    logic [6:0]  rd_addr;

    // Channel controls are looked up only for the channel currently being serviced.
    assign ch_en   = ChannelStatus[{ch_q, 1'b0}];
    assign ch_bank = ChannelStatus[{ch_q, 1'b1}];
    assign ch_idx  = WavetableIndices[({3'b000, ch_q} * 5'd6) +: 6];
    assign rd_addr = {ch_bank, ch_idx};

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        MemRE   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Tick) begin
                    ch_d    = 2'd0;
                    state_d = READ;
                end
            end
            READ: begin
                if (ch_en) begin
                    MemRE   = 1'b1;
                    state_d = WAIT;
                end else if (ch_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    ch_d    = ch_q + 2'd1;
                    state_d = READ;
                end
            end
            WAIT: begin
                if (ch_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    ch_d    = ch_q + 2'd1;
                    state_d = READ;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address is presented combinationally during the read and held afterwards.
    assign MemAddr     = MemRE ? rd_addr : addr_q;
    assign FrameStrobe = (state_q == DONE);
    assign Busy        = (state_q != IDLE);
    assign Samples     = samples_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            ch_q        <= 2'd0;
            addr_q      <= 7'd0;
            samples_q   <= {4{IDLE_LEVEL}};
            SampleValid <= 4'b0000;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            SampleValid <= 4'b0000;
            if (MemRE) begin
                addr_q <= rd_addr;
            end
            if (state_q == READ && !ch_en) begin
                samples_q[{ch_q, 3'b000} +: 8] <= IDLE_LEVEL;
                SampleValid[ch_q]              <= 1'b1;
            end
            if (state_q == WAIT) begin
                samples_q[{ch_q, 3'b000} +: 8] <= MemData;
                SampleValid[ch_q]              <= 1'b1;
            end
        end
    end

`ifdef WAVETABLE_SCHEDULER_OVERRUN_EN
    logic overrun_q;

    // Setting wins over a clear in the same cycle so no drop goes unreported.
    always_ff @(posedge CLK) begin
        if (RST) begin
            overrun_q <= 1'b0;
        end else if (Tick && Busy) begin
            overrun_q <= 1'b1;
        end else if (OverrunClr) begin
            overrun_q <= 1'b0;
        end
    end

    assign Overrun = overrun_q;
`else
    logic unused_overrun_clr;

    assign unused_overrun_clr = OverrunClr;
    assign Overrun            = 1'b0;
`endif

endmodule

// File: tb/tb_wavetable_scheduler.sv
// Directed bench for wavetable_scheduler: frame timing, sample contents, drop/overrun, reset behaviour.
module tb_wavetable_scheduler;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Tick;
    logic [23:0] WavetableIndices;
    logic [7:0]  ChannelStatus;
    logic        MemRE;
    logic [6:0]  MemAddr;
    logic [7:0]  MemData = 8'h00;
    logic [31:0] Samples;
    logic [3:0]  SampleValid;
    logic        FrameStrobe;
    logic        Busy;
    logic        OverrunClr;
    logic        Overrun;

    logic [7:0]  ram [128];
    int          n_vec = 0;
    int          n_err = 0;
    int          re_cnt;
    int          fs_cnt;

`ifdef WAVETABLE_SCHEDULER_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    wavetable_scheduler dut (
        .CLK              (CLK),
        .RST              (RST),
        .Tick             (Tick),
        .WavetableIndices (WavetableIndices),
        .ChannelStatus    (ChannelStatus),
        .MemRE            (MemRE),
        .MemAddr          (MemAddr),
        .MemData          (MemData),
        .Samples          (Samples),
        .SampleValid      (SampleValid),
        .FrameStrobe      (FrameStrobe),
        .Busy             (Busy),
        .OverrunClr       (OverrunClr),
        .Overrun          (Overrun)
    );

    always #5 CLK = ~CLK;

    // Synchronous wavetable RAM: data appears the cycle after the read strobe.
    always @(posedge CLK) begin
        if (MemRE) MemData <= ram[MemAddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int a = 0; a < 128; a++) ram[a] = 8'(a + 8'h10);
        RST = 1'b1; Tick = 1'b0; OverrunClr = 1'b0;
        WavetableIndices = '0; ChannelStatus = '0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_busy", Busy, 0);
        chk("rst_re", MemRE, 0);
        chk("rst_addr", MemAddr, 0);
        chk("rst_samples", Samples, 32'h80808080);
        chk("rst_sv", SampleValid, 0);
        chk("rst_fs", FrameStrobe, 0);
        chk("rst_ovr", Overrun, 0);
        RST = 1'b0;
        @(negedge CLK);

        // Scenario 1: all channels enabled, bank 0, indices 1..4
        WavetableIndices = {6'd4, 6'd3, 6'd2, 6'd1};
        ChannelStatus    = 8'b01_01_01_01;
        Tick = 1'b1;
        @(negedge CLK);
        Tick = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            logic re_exp;
            logic [3:0] sv_exp;
            re_exp = (c == 1 || c == 3 || c == 5 || c == 7);
            sv_exp = (c == 3) ? 4'h1 : (c == 5) ? 4'h2 : (c == 7) ? 4'h4 : (c == 9) ? 4'h8 : 4'h0;
            chk("s1_re", MemRE, re_exp);
            if (re_exp) chk("s1_addr", MemAddr, (c + 1) / 2);
            chk("s1_fs", FrameStrobe, c == 9);
            chk("s1_sv", SampleValid, sv_exp);
            @(negedge CLK);
        end
        chk("s1_samples", Samples, 32'h14131211);
        chk("s1_busy", Busy, 0);

        // Scenario 2: only ch1 enabled, bank 1, index 5
        ram[69] = 8'hAA;
        WavetableIndices = {6'd0, 6'd0, 6'd5, 6'd0};
        ChannelStatus    = 8'b00_00_11_00;
        re_cnt = 0;
        Tick = 1'b1;
        @(negedge CLK);
        Tick = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (MemRE) begin
                re_cnt++;
                chk("s2_addr", MemAddr, 69);
            end
            chk("s2_re", MemRE, c == 2);
            chk("s2_fs", FrameStrobe, c == 6);
            @(negedge CLK);
        end
        chk("s2_re_cnt", re_cnt, 1);
        chk("s2_samples", Samples, 32'h8080AA80);
        chk("s2_addr_hold", MemAddr, 69);

        // Scenario 3: second Tick at cycle 4 is dropped
        WavetableIndices = {6'd4, 6'd3, 6'd2, 6'd1};
        ChannelStatus    = 8'b01_01_01_01;
        fs_cnt = 0;
        Tick = 1'b1;
        @(negedge CLK);
        Tick = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            chk("s3_ovr", Overrun, (c >= 5 && c <= 12) ? OVR_EXP : 1'b0);
            chk("s3_fs", FrameStrobe, c == 9);
            chk("s3_busy", Busy, c <= 9);
            if (FrameStrobe) fs_cnt++;
            Tick       = (c == 4);
            OverrunClr = (c == 12);
            @(negedge CLK);
        end
        chk("s3_fs_cnt", fs_cnt, 1);
        chk("s3_samples", Samples, 32'h14131211);

        // Scenario 4: reset during the WAIT of channel 1
        Tick = 1'b1;
        @(negedge CLK);
        Tick = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("s4_busy_pre", Busy, 1);
            if (c == 4) RST = 1'b1;
            @(negedge CLK);
        end
        RST = 1'b0;
        chk("s4_busy", Busy, 0);
        chk("s4_samples", Samples, 32'h80808080);
        chk("s4_sv", SampleValid, 0);
        for (int c = 6; c <= 12; c++) begin
            chk("s4_fs", FrameStrobe, 0);
            chk("s4_sv_after", SampleValid, 0);
            chk("s4_idle", Busy, 0);
            @(negedge CLK);
        end
        chk("s4_samples_after", Samples, 32'h80808080);

        // Scenario 5: reset beats Tick; then maximum address
        Tick = 1'b1; RST = 1'b1;
        @(negedge CLK);
        Tick = 1'b0; RST = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("s5_busy", Busy, 0);
            chk("s5_re", MemRE, 0);
            @(negedge CLK);
        end
        WavetableIndices = {6'd63, 18'd0};
        ChannelStatus    = 8'b11_00_00_00;
        Tick = 1'b1;
        @(negedge CLK);
        Tick = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            chk("s5_re_max", MemRE, c == 4);
            if (MemRE) chk("s5_addr_max", MemAddr, 127);
            chk("s5_fs", FrameStrobe, c == 6);
            @(negedge CLK);
        end
        chk("s5_samples", Samples, 32'h8F808080);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
